pwm_multi: RTL

Multi-channel PWM generator with a shared prescaler and a runtime-programmable period. Each channel has its own duty value. Duty and period updates are double-buffered and take effect only at a period boundary, so no output ever sees a glitched or truncated cycle. It drives the board LEDs (active-low by default) and generalises the single-channel 4-bit switch-driven PWM to N channels and W-bit resolution, with optional duty fading.

---
 rtl/pwm_pkg.sv | 19 +
 rtl/clkdiv.sv | 26 ++
 rtl/pwm_chan.sv | 81 ++++++++
 rtl/pwm_multi.sv | 109 ++++++++++
 4 files changed

// File: rtl/pwm_pkg.sv
// Shared constants and helpers for the multi-channel PWM block.
// Board LED polarity, the default 27 MHz prescale value and duty-bus slicing.
package pwm_pkg;

    localparam logic LED_ON  = 1'b0;
    localparam logic LED_OFF = 1'b1;

    // 27 MHz / (106 * 256) gives roughly a 1 kHz PWM frame at WIDTH = 8.
    localparam logic [25:0] PRESCALE_27M_1K = 26'd105;

    function automatic logic [15:0] chan_duty(input logic [255:0] duty_bus,
                                              input int           ch,
                                              input int           width);
        logic [255:0] shifted;
        shifted = duty_bus >> (ch * width);
        return shifted[15:0] & ((16'h1 << width) - 16'h1);
    endfunction

endpackage

// File: rtl/clkdiv.sv
// Free-running terminal-count divider: tc is high while the count equals TC.
// clr holds the count at zero.
module clkdiv #(
    parameter logic [25:0] TC = 26'd105
) (
    input  logic clk,
    input  logic nrst,
    input  logic clr,
    output logic tc
);

    logic [25:0] r_cnt;

    always_ff @(posedge clk) begin
        if (!nrst || clr) begin
            r_cnt <= '0;
        end else if (r_cnt == TC) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 26'd1;
        end
    end

    assign tc = (r_cnt == TC);

endmodule

// File: rtl/pwm_chan.sv
// One PWM channel: double-buffered duty, compare against the shared counter, registered output.
// With PWM_FADE_EN the pending register becomes a target and duty steps by one per commit.
module pwm_chan
    import pwm_pkg::*;
#(
    parameter int   WIDTH      = 8,
    parameter logic ACTIVE_LOW = 1'b1
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic             i_en,
    input  logic [WIDTH-1:0] i_cnt,
    input  logic [WIDTH-1:0] i_duty,
    input  logic             i_load,
    input  logic             i_commit,
`ifdef PWM_FADE_EN
    output logic             o_busy,
`else
    input  logic             i_have_pend,
`endif
    output logic             o_out
);

    localparam logic OUT_OFF = ACTIVE_LOW ? LED_OFF : LED_ON;
    localparam logic OUT_ON  = ~OUT_OFF;

    logic [WIDTH-1:0] r_duty_act;
    logic             r_out;
    logic             w_on;

    assign w_on  = i_en && (i_cnt < r_duty_act);
    assign o_out = r_out;

`ifdef PWM_FADE_EN
    logic [WIDTH-1:0] r_target;
    logic [WIDTH-1:0] w_target;

    // A load on the commit cycle retargets before this step is taken.
    assign w_target = i_load ? i_duty : r_target;
    assign o_busy   = (r_duty_act != r_target);

    always_ff @(posedge clk) begin
        if (!nrst) begin
            r_duty_act <= '0;
            r_target   <= '0;
            r_out      <= OUT_OFF;
        end else begin
            if (i_load) begin
                r_target <= i_duty;
            end
            if (i_commit) begin
                if (r_duty_act < w_target) begin
                    r_duty_act <= r_duty_act + WIDTH'(1);
                end else if (r_duty_act > w_target) begin
                    r_duty_act <= r_duty_act - WIDTH'(1);
                end
            end
            r_out <= w_on ? OUT_ON : OUT_OFF;
        end
    end
`else
    logic [WIDTH-1:0] r_duty_pend;

    always_ff @(posedge clk) begin
        if (!nrst) begin
            r_duty_act  <= '0;
            r_duty_pend <= '0;
            r_out       <= OUT_OFF;
        end else begin
            if (i_load) begin
                r_duty_pend <= i_duty;
            end
            if (i_commit && (i_load || i_have_pend)) begin
                r_duty_act <= i_load ? i_duty : r_duty_pend;
            end
            r_out <= w_on ? OUT_ON : OUT_OFF;
        end
    end
`endif

endmodule

// File: rtl/pwm_multi.sv
// N-channel PWM with shared prescaler, runtime period and boundary-synchronised updates.
// Optional duty fading is enabled by defining PWM_FADE_EN.
module pwm_multi
    import pwm_pkg::*;
#(
    parameter int          NCH        = 4,
    parameter int          WIDTH      = 8,
    parameter logic [25:0] PRESCALE   = PRESCALE_27M_1K,
    parameter logic        ACTIVE_LOW = 1'b1
) (
    input  logic                 clk,
    input  logic                 nrst,
    input  logic                 en,
    input  logic [WIDTH-1:0]     period,
    input  logic [NCH*WIDTH-1:0] duty,
    input  logic                 load,
    output logic                 upd_pend,
    output logic                 cyc_tc,
    output logic [NCH-1:0]       pwm_out
);

    logic             w_tc;
    logic             w_tick;
    logic             w_boundary;
    logic             w_commit;
    logic             w_apply;
    logic [WIDTH-1:0] r_cnt;
    logic [WIDTH-1:0] r_per_act;
    logic [WIDTH-1:0] r_per_pend;
    logic             r_upd_pend;
    logic             r_cyc_tc;
    logic [WIDTH-1:0] w_duty_ch [NCH];

    clkdiv #(.TC(PRESCALE)) u_clkdiv (
        .clk  (clk),
        .nrst (nrst),
        .clr  (~en),
        .tc   (w_tc)
    );

    assign w_tick     = en && w_tc;
    assign w_boundary = w_tick && (r_cnt == r_per_act);
    // While disabled every edge acts as a commit point so updates land immediately.
    assign w_commit   = w_boundary || !en;
    assign w_apply    = w_commit && (load || r_upd_pend);

    always_ff @(posedge clk) begin
        if (!nrst) begin
            r_cnt      <= '0;
            r_per_act  <= '0;
            r_per_pend <= '0;
            r_upd_pend <= 1'b0;
            r_cyc_tc   <= 1'b0;
        end else begin
            r_cyc_tc <= w_boundary;
            if (!en || w_boundary) begin
                r_cnt <= '0;
            end else if (w_tick) begin
                r_cnt <= r_cnt + WIDTH'(1);
            end
            if (w_apply) begin
                r_per_act <= load ? period : r_per_pend;
            end
            if (load) begin
                r_per_pend <= period;
            end
            if (w_commit) begin
                r_upd_pend <= 1'b0;
            end else if (load) begin
                r_upd_pend <= 1'b1;
            end
        end
    end

    assign cyc_tc = r_cyc_tc;

`ifdef PWM_FADE_EN
    logic [NCH-1:0] w_busy;
    assign upd_pend = r_upd_pend || (|w_busy);
`else
    assign upd_pend = r_upd_pend;
`endif

    generate
        for (genvar gi = 0; gi < NCH; gi++) begin : g_chan
            assign w_duty_ch[gi] = WIDTH'(chan_duty(256'(duty), gi, WIDTH));

            pwm_chan #(
                .WIDTH      (WIDTH),
                .ACTIVE_LOW (ACTIVE_LOW)
            ) u_chan (
                .clk         (clk),
                .nrst        (nrst),
                .i_en        (en),
                .i_cnt       (r_cnt),
                .i_duty      (w_duty_ch[gi]),
                .i_load      (load),
                .i_commit    (w_commit),
`ifdef PWM_FADE_EN
                .o_busy      (w_busy[gi]),
`else
                .i_have_pend (r_upd_pend),
`endif
                .o_out       (pwm_out[gi])
            );
        end
    endgenerate

endmodule
